// File: rtl/branch_flush_ctrl.sv
// Redirect/flush sequencer: steers the PC to a taken-branch target and squashes the
// wrong-path instructions for FLUSH_DEPTH advancing cycles, freezing while the pipeline stalls.
module branch_flush_ctrl #(
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned FLUSH_DEPTH = 3,
    parameter int unsigned CNT_W       = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              redirect_req,
    input  logic [ADDR_W-1:0] redirect_target,
    input  logic              stall_in,
    output logic              pc_sel,
    output logic [ADDR_W-1:0] pc_target,
    output logic              squash_ifid,
    output logic              squash_idex,
    output logic              kill_wr,
    output logic              busy,
    output logic              misalign_err,
    output logic [CNT_W-1:0]  redirect_cnt
);

    localparam logic [3:0] DepthInit = 4'(FLUSH_DEPTH);

    typedef enum logic [1:0] {
        StIdle,
        StRedir,
        StDrain
    } state_e;

    state_e             state_q, state_d;
    logic [3:0]         cnt_q, cnt_d;
    logic               accept;

    logic               pc_sel_q, pc_sel_d;
    logic               squash_q, squash_d;
    logic               misalign_q, misalign_d;
    logic [ADDR_W-1:0]  pc_target_q, pc_target_d;
    logic [CNT_W-1:0]   redirect_cnt_q, redirect_cnt_d;

    // State, squash counter and all registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= StIdle;
            cnt_q          <= '0;
            pc_sel_q       <= 1'b0;
            squash_q       <= 1'b0;
            misalign_q     <= 1'b0;
            pc_target_q    <= '0;
            redirect_cnt_q <= '0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            pc_sel_q       <= pc_sel_d;
            squash_q       <= squash_d;
            misalign_q     <= misalign_d;
            pc_target_q    <= pc_target_d;
            redirect_cnt_q <= redirect_cnt_d;
        end
    end

    // Requests while busy come from squashed wrong-path instructions and are dropped.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        accept  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (redirect_req) begin
                    accept  = 1'b1;
                    cnt_d   = DepthInit;
                    state_d = StRedir;
                end
            end
            StRedir, StDrain: begin
                if (!stall_in) begin
                    cnt_d   = cnt_q - 4'd1;
                    state_d = (cnt_d == 4'd0) ? StIdle : StDrain;
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase
    end

    // Outputs are computed from the next state so they register alongside it.
    always_comb begin
        pc_sel_d       = (state_d == StRedir);
        squash_d       = (state_d != StIdle);
        misalign_d     = accept && (redirect_target[1:0] != 2'b00);
        pc_target_d    = accept ? redirect_target : pc_target_q;
        redirect_cnt_d = redirect_cnt_q;
        if (accept && (redirect_cnt_q != {CNT_W{1'b1}})) begin
            redirect_cnt_d = redirect_cnt_q + 1'b1;
        end
    end

    assign pc_sel       = pc_sel_q;
    assign pc_target    = pc_target_q;
    assign squash_ifid  = squash_q;
    assign squash_idex  = squash_q;
    assign kill_wr      = squash_q;
    assign busy         = squash_q;
    assign misalign_err = misalign_q;
    assign redirect_cnt = redirect_cnt_q;

endmodule
